adder_tree_acc: RTL and testbench

//  Parametrised pipelined adder tree: sums NUM operands of BITS each, one tree level per clock, full precision.

---
 rtl/adder_tree_acc_if.sv | 26 ++
 rtl/adder_tree_acc.sv | 142 ++++++++++++++
 tb/tb_adder_tree_acc.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/adder_tree_acc_if.sv
// Stream bundle for adder_tree_acc: operand beat in (valid/ready/last) and result beat out
// (valid_out/ready_out/last_out). OW must match the attached tree's derived output width.
interface adder_tree_acc_if #(
  parameter int BITS = 8,
  parameter int NUM  = 4,
  parameter int OW   = 10
);
  logic                  valid;
  logic                  ready;
  logic                  last;
  logic [NUM*BITS-1:0]   data_in;
  logic [OW-1:0]         o;
  logic                  valid_out;
  logic                  last_out;
  logic                  ready_out;

  modport master (
    output valid, last, data_in, ready_out,
    input  ready, o, valid_out, last_out
  );

  modport slave (
    input  valid, last, data_in, ready_out,
    output ready, o, valid_out, last_out
  );
endinterface

// File: rtl/adder_tree_acc.sv
// Pipelined full-precision adder tree (one level per clock) with global-stall backpressure
// and an optional per-frame accumulator stage on the output.
module adder_tree_acc #(
  parameter int BITS     = 8,
  parameter int NUM      = 4,
  parameter int SIGNED   = 0,
  parameter int ACCUM    = 0,
  parameter int ACC_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  adder_tree_acc_if.slave   bus
);
  // Operand count at level k is ceil(NUM / 2^k); all levels live in one flat node array.
  function automatic int cnt(input int k);
    return (NUM + (1 << k) - 1) >> k;
  endfunction

  function automatic int off(input int k);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s += cnt(i);
    return s;
  endfunction

  localparam int LVL   = $clog2(NUM);
  localparam int SW    = BITS + LVL;
  localparam int OW    = SW + ((ACCUM != 0) ? ACC_BITS : 0);
  localparam int TOTAL = off(LVL + 1);

  logic          en;
  logic          valid_out_int;
  logic [SW-1:0] node_reg  [TOTAL];
  logic [SW-1:0] node_next [TOTAL];
  logic [LVL:0]  vld_reg;
  logic [LVL:0]  lst_reg;
  logic [SW-1:0] tree_sum;
  logic          tree_vld;
  logic          tree_lst;

  assign en        = !valid_out_int | bus.ready_out;
  assign bus.ready = en;

  genvar gi, gj;

  // Level 0: operands widened to the full tree width.
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_ext
      if (SIGNED != 0) begin : g_sx
        assign node_next[gi] = SW'(signed'(bus.data_in[gi*BITS +: BITS]));
      end else begin : g_zx
        assign node_next[gi] = SW'(bus.data_in[gi*BITS +: BITS]);
      end
    end
  endgenerate

  // Levels 1..LVL: pairwise sums; an odd leftover is carried through a register unchanged.
  generate
    for (gi = 1; gi <= LVL; gi++) begin : g_lvl
      localparam int PC = cnt(gi - 1);
      localparam int PO = off(gi - 1);
      localparam int CO = off(gi);
      for (gj = 0; gj < cnt(gi); gj++) begin : g_node
        if (2*gj + 1 < PC) begin : g_add
          assign node_next[CO+gj] = node_reg[PO+2*gj] + node_reg[PO+2*gj+1];
        end else begin : g_pass
          assign node_next[CO+gj] = node_reg[PO+2*gj];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
      lst_reg <= '0;
      for (int i = 0; i < TOTAL; i++) node_reg[i] <= '0;
    end else if (en) begin
      node_reg   <= node_next;
      vld_reg[0] <= bus.valid;
      lst_reg[0] <= bus.valid & bus.last;
      for (int i = 1; i <= LVL; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        lst_reg[i] <= lst_reg[i-1];
      end
    end
  end

  assign tree_sum = node_reg[TOTAL-1];
  assign tree_vld = vld_reg[LVL];
  assign tree_lst = lst_reg[LVL];

  generate
    if (ACCUM == 0) begin : g_direct
      assign bus.o         = tree_sum;
      assign valid_out_int = tree_vld;
      assign bus.last_out  = tree_lst;
    end else begin : g_accum
      logic [OW-1:0] acc_reg;
      logic [OW-1:0] o_reg;
      logic [OW-1:0] sum_ext;
      logic [OW-1:0] acc_next;
      logic          frame_start_reg;
      logic          valid_out_reg;
      logic          last_out_reg;

      if (SIGNED != 0) begin : g_sx
        assign sum_ext = OW'(signed'(tree_sum));
      end else begin : g_zx
        assign sum_ext = OW'(tree_sum);
      end

      // Accumulator wraps modulo 2^OW; the first beat of a frame starts from zero.
      assign acc_next = (frame_start_reg ? '0 : acc_reg) + sum_ext;

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_reg         <= '0;
          o_reg           <= '0;
          frame_start_reg <= 1'b1;
          valid_out_reg   <= 1'b0;
          last_out_reg    <= 1'b0;
        end else if (en) begin
          valid_out_reg <= tree_vld & tree_lst;
          last_out_reg  <= tree_vld & tree_lst;
          if (tree_vld) begin
            acc_reg         <= acc_next;
            frame_start_reg <= tree_lst;
            if (tree_lst) o_reg <= acc_next;
          end
        end
      end

      assign bus.o         = o_reg;
      assign valid_out_int = valid_out_reg;
      assign bus.last_out  = last_out_reg;
    end
  endgenerate

  assign bus.valid_out = valid_out_int;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc across several parameterisations sharing one clock/reset.
module tb_adder_tree_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  adder_tree_acc_if #(.BITS(8), .NUM(4), .OW(10)) bus_a ();
  adder_tree_acc_if #(.BITS(8), .NUM(5), .OW(11)) bus_b ();
  adder_tree_acc_if #(.BITS(8), .NUM(2), .OW(17)) bus_c ();
  adder_tree_acc_if #(.BITS(8), .NUM(1), .OW(8))  bus_d ();
  adder_tree_acc_if #(.BITS(8), .NUM(3), .OW(10)) bus_e ();

  adder_tree_acc #(.BITS(8), .NUM(4), .SIGNED(0), .ACCUM(0), .ACC_BITS(8))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  adder_tree_acc #(.BITS(8), .NUM(5), .SIGNED(1), .ACCUM(0), .ACC_BITS(8))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  adder_tree_acc #(.BITS(8), .NUM(2), .SIGNED(0), .ACCUM(1), .ACC_BITS(8))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));
  adder_tree_acc #(.BITS(8), .NUM(1), .SIGNED(0), .ACCUM(0), .ACC_BITS(8))
    dut_d (.clk(clk), .rst(rst), .bus(bus_d));
  adder_tree_acc #(.BITS(8), .NUM(3), .SIGNED(0), .ACCUM(0), .ACC_BITS(8))
    dut_e (.clk(clk), .rst(rst), .bus(bus_e));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Backpressure stream beat i: operands (30i, 255, i, 7), sum 31i + 262.
  function automatic logic [31:0] beat_a(input int i);
    logic [7:0] x;
    logic [7:0] y;
    x = 8'(i * 30);
    y = 8'(i);
    return {8'd7, y, 8'd255, x};
  endfunction

  initial begin
    int sent, recv, stalls;

    bus_a.valid = 0; bus_a.last = 0; bus_a.data_in = '0; bus_a.ready_out = 0;
    bus_b.valid = 0; bus_b.last = 0; bus_b.data_in = '0; bus_b.ready_out = 1;
    bus_c.valid = 0; bus_c.last = 0; bus_c.data_in = '0; bus_c.ready_out = 1;
    bus_d.valid = 0; bus_d.last = 0; bus_d.data_in = '0; bus_d.ready_out = 1;
    bus_e.valid = 0; bus_e.last = 0; bus_e.data_in = '0; bus_e.ready_out = 1;

    // Reset state
    tick(); tick();
    rst = 0;
    #1;
    chk("reset_a_valid_out", 64'(bus_a.valid_out), 0);
    chk("reset_a_o", 64'(bus_a.o), 0);
    chk("reset_a_ready", 64'(bus_a.ready), 1);
    chk("reset_c_valid_out", 64'(bus_c.valid_out), 0);
    chk("reset_c_o", 64'(bus_c.o), 0);
    chk("reset_c_last_out", 64'(bus_c.last_out), 0);
    bus_a.ready_out = 1;

    // Test 1: 1+2+3+4 = 10, valid_out exactly 3 edges after accept
    bus_a.valid = 1; bus_a.data_in = {8'd4, 8'd3, 8'd2, 8'd1};
    tick();
    bus_a.valid = 0;
    chk("t1_vo_lat1", 64'(bus_a.valid_out), 0);
    tick();
    chk("t1_vo_lat2", 64'(bus_a.valid_out), 0);
    tick();
    chk("t1_vo_lat3", 64'(bus_a.valid_out), 1);
    chk("t1_o", 64'(bus_a.o), 10);
    tick();
    chk("t1_vo_drop", 64'(bus_a.valid_out), 0);

    // Test 2: signed NUM=5, -640 then 635 back-to-back (11-bit: -640 -> 1408)
    bus_b.valid = 1; bus_b.data_in = {5{8'h80}};
    tick();
    bus_b.data_in = {5{8'h7f}};
    tick();
    bus_b.valid = 0;
    tick();
    chk("t2_vo_early", 64'(bus_b.valid_out), 0);
    tick();
    chk("t2_vo_first", 64'(bus_b.valid_out), 1);
    chk("t2_o_neg", 64'(bus_b.o), 1408);
    tick();
    chk("t2_vo_second", 64'(bus_b.valid_out), 1);
    chk("t2_o_pos", 64'(bus_b.o), 635);
    tick();
    chk("t2_vo_drop", 64'(bus_b.valid_out), 0);

    // Test 3: 8-beat stream with ready_out low for 4 cycles mid-stream
    sent = 0; recv = 0; stalls = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus_a.ready_out = !(cyc >= 6 && cyc < 10);
      bus_a.valid = (sent < 8);
      bus_a.data_in = beat_a(sent);
      @(negedge clk);
      if (bus_a.valid_out) begin
        chk("t3_o", 64'(bus_a.o), 64'(31 * recv + 262));
        if (bus_a.ready_out) recv++;
        else begin
          stalls++;
          chk("t3_ready_low", 64'(bus_a.ready), 0);
        end
      end
      if (bus_a.valid && bus_a.ready) sent++;
      tick();
    end
    bus_a.valid = 0; bus_a.ready_out = 1;
    chk("t3_sent", 64'(sent), 8);
    chk("t3_recv", 64'(recv), 8);
    chk("t3_stalls", 64'(stalls), 4);

    // Test 4: accumulate (1,1),(2,2),(3,3 last) -> 12, then new frame (5,5 last) -> 10
    bus_c.valid = 1; bus_c.last = 0; bus_c.data_in = {8'd1, 8'd1};
    tick();
    chk("t4_vo_b1", 64'(bus_c.valid_out), 0);
    bus_c.data_in = {8'd2, 8'd2};
    tick();
    chk("t4_vo_b2", 64'(bus_c.valid_out), 0);
    bus_c.data_in = {8'd3, 8'd3}; bus_c.last = 1;
    tick();
    chk("t4_vo_b3", 64'(bus_c.valid_out), 0);
    bus_c.valid = 0; bus_c.last = 0;
    tick();
    chk("t4_vo_b4", 64'(bus_c.valid_out), 0);
    tick();
    chk("t4_vo_frame", 64'(bus_c.valid_out), 1);
    chk("t4_o_frame", 64'(bus_c.o), 12);
    chk("t4_last_out", 64'(bus_c.last_out), 1);
    tick();
    chk("t4_vo_drop", 64'(bus_c.valid_out), 0);
    bus_c.valid = 1; bus_c.last = 1; bus_c.data_in = {8'd5, 8'd5};
    tick();
    bus_c.valid = 0; bus_c.last = 0;
    tick(); tick();
    chk("t4_vo_frame2", 64'(bus_c.valid_out), 1);
    chk("t4_o_frame2", 64'(bus_c.o), 10);
    tick();

    // Test 5: reset with beats in flight (A stalled) and a partial frame in C
    bus_a.ready_out = 0;
    bus_a.valid = 1; bus_a.data_in = {4{8'd9}};
    bus_c.valid = 1; bus_c.last = 0;
    for (int i = 0; i < 3; i++) begin
      bus_c.data_in = {8'(7 + i), 8'(7 + i)};
      tick();
    end
    bus_a.valid = 0; bus_c.valid = 0;
    chk("t5_a_stalled_vo", 64'(bus_a.valid_out), 1);
    rst = 1;
    tick();
    rst = 0;
    chk("t5_a_vo", 64'(bus_a.valid_out), 0);
    chk("t5_a_o", 64'(bus_a.o), 0);
    chk("t5_a_ready", 64'(bus_a.ready), 1);
    chk("t5_c_vo", 64'(bus_c.valid_out), 0);
    chk("t5_c_o", 64'(bus_c.o), 0);
    bus_a.ready_out = 1;
    bus_a.valid = 1; bus_a.data_in = {4{8'd1}};
    bus_c.valid = 1; bus_c.last = 1; bus_c.data_in = {8'd2, 8'd1};
    tick();
    bus_a.valid = 0; bus_c.valid = 0; bus_c.last = 0;
    chk("t5_a_vo_post1", 64'(bus_a.valid_out), 0);
    chk("t5_c_vo_post1", 64'(bus_c.valid_out), 0);
    tick();
    chk("t5_a_vo_post2", 64'(bus_a.valid_out), 0);
    chk("t5_c_vo_post2", 64'(bus_c.valid_out), 0);
    tick();
    chk("t5_a_vo_new", 64'(bus_a.valid_out), 1);
    chk("t5_a_o_new", 64'(bus_a.o), 4);
    chk("t5_c_vo_new", 64'(bus_c.valid_out), 1);
    chk("t5_c_o_new", 64'(bus_c.o), 3);

    // Test 6: NUM=1 and NUM=3 with unsigned max operands
    bus_d.valid = 1; bus_d.data_in = 8'hff;
    bus_e.valid = 1; bus_e.data_in = {3{8'hff}};
    tick();
    bus_d.valid = 0; bus_e.valid = 0;
    chk("t6_d_vo", 64'(bus_d.valid_out), 1);
    chk("t6_d_o", 64'(bus_d.o), 255);
    chk("t6_e_vo_early", 64'(bus_e.valid_out), 0);
    tick();
    chk("t6_d_vo_drop", 64'(bus_d.valid_out), 0);
    chk("t6_e_vo_mid", 64'(bus_e.valid_out), 0);
    tick();
    chk("t6_e_vo", 64'(bus_e.valid_out), 1);
    chk("t6_e_o", 64'(bus_e.o), 765);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
